// File: rtl/calc_entry_ctrl.sv
// Calculator entry controller: builds hex operands from keypad keystrokes, latches
// the operator, evaluates on EXE or on a chained operator and selects the display value.
module calc_entry_ctrl #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_press,
    input  logic [4:0]       key_val,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic [2:0]       op_code,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] display,
    output logic [1:0]       state,
    output logic             overflow,
    output logic             result_valid
);

    localparam int unsigned CW = $clog2(DIGITS + 1);
    localparam int unsigned SW = WIDTH + 1;
    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_MUL = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;

    typedef enum logic [1:0] {
        S_ENTER_A  = 2'd0,
        S_OP_SET   = 2'd1,
        S_ENTER_B  = 2'd2,
        S_SHOW_RES = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] disp_q, disp_d;
    logic [2:0]       op_q, op_d;
    logic             ovf_q, ovf_d;
    logic             rv_q, rv_d;
    logic [CW-1:0]    cnt_a_q, cnt_a_d;
    logic [CW-1:0]    cnt_b_q, cnt_b_d;

    logic             k_digit, k_op, k_exe, k_ce, k_clr;
    logic [2:0]       k_opsel;
    logic [WIDTH-1:0] digit;
    logic             clear_all;

    logic [SW-1:0]    sum;
    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    // Keystroke decode; invalid codes fall through with every strobe low.
    always_comb begin
        k_digit = 1'b0;
        k_op    = 1'b0;
        k_exe   = 1'b0;
        k_ce    = 1'b0;
        k_clr   = 1'b0;
        k_opsel = OP_ADD;
        if (key_press) begin
            if (!key_val[4]) begin
                k_digit = 1'b1;
            end else begin
                case (key_val[3:0])
                    4'h0:    begin k_op = 1'b1; k_opsel = OP_ADD; end
                    4'h1:    begin k_op = 1'b1; k_opsel = OP_MUL; end
                    4'h2:    begin k_op = 1'b1; k_opsel = OP_AND; end
                    4'h3:    k_exe = 1'b1;
                    4'h4:    begin k_op = 1'b1; k_opsel = OP_SUB; end
                    4'h5:    begin k_op = 1'b1; k_opsel = OP_OR;  end
                    4'h6:    k_ce  = 1'b1;
                    4'h7:    k_clr = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign digit = WIDTH'(key_val[3:0]);

    // ALU on the registered operands and operator.
    always_comb begin
        sum     = SW'(a_q) + SW'(b_q);
        prod    = PW'(a_q) * PW'(b_q);
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_q)
            OP_ADD: begin alu_res = sum[WIDTH-1:0];  alu_ovf = sum[WIDTH];           end
            OP_MUL: begin alu_res = prod[WIDTH-1:0]; alu_ovf = |prod[PW-1:WIDTH];    end
            OP_AND: alu_res = a_q & b_q;
            OP_SUB: begin alu_res = a_q - b_q;       alu_ovf = (a_q < b_q);          end
            OP_OR:  alu_res = a_q | b_q;
            default: ;
        endcase
    end

    // CE while a result is shown behaves exactly like CLR.
    assign clear_all = k_clr | (k_ce & (state_q == S_SHOW_RES));

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        op_d    = op_q;
        ovf_d   = ovf_q;
        rv_d    = 1'b0;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        disp_d  = disp_q;

        if (clear_all) begin
            state_d = S_ENTER_A;
            a_d     = '0;
            b_d     = '0;
            res_d   = '0;
            op_d    = OP_ADD;
            ovf_d   = 1'b0;
            cnt_a_d = '0;
            cnt_b_d = '0;
        end else begin
            case (state_q)
                S_ENTER_A: begin
                    if (k_digit && (cnt_a_q < CW'(DIGITS))) begin
                        a_d     = (a_q << 4) | digit;
                        cnt_a_d = cnt_a_q + CW'(1);
                    end else if (k_op) begin
                        op_d    = k_opsel;
                        state_d = S_OP_SET;
                    end else if (k_ce) begin
                        a_d     = '0;
                        cnt_a_d = '0;
                    end
                end
                S_OP_SET: begin
                    if (k_digit) begin
                        b_d     = digit;
                        cnt_b_d = CW'(1);
                        state_d = S_ENTER_B;
                    end else if (k_op) begin
                        op_d = k_opsel;
                    end else if (k_ce) begin
                        state_d = S_ENTER_A;
                    end
                end
                S_ENTER_B: begin
                    if (k_digit && (cnt_b_q < CW'(DIGITS))) begin
                        b_d     = (b_q << 4) | digit;
                        cnt_b_d = cnt_b_q + CW'(1);
                    end else if (k_exe) begin
                        res_d   = alu_res;
                        ovf_d   = alu_ovf;
                        rv_d    = 1'b1;
                        state_d = S_SHOW_RES;
                    end else if (k_op) begin
                        // Chained operator: the result becomes a full-length A.
                        res_d   = alu_res;
                        ovf_d   = alu_ovf;
                        rv_d    = 1'b1;
                        a_d     = alu_res;
                        cnt_a_d = CW'(DIGITS);
                        b_d     = '0;
                        cnt_b_d = '0;
                        op_d    = k_opsel;
                        state_d = S_OP_SET;
                    end else if (k_ce) begin
                        b_d     = '0;
                        cnt_b_d = '0;
                    end
                end
                S_SHOW_RES: begin
                    if (k_digit) begin
                        a_d     = digit;
                        cnt_a_d = CW'(1);
                        b_d     = '0;
                        cnt_b_d = '0;
                        state_d = S_ENTER_A;
                    end else if (k_op) begin
                        a_d     = res_q;
                        cnt_a_d = CW'(DIGITS);
                        b_d     = '0;
                        cnt_b_d = '0;
                        op_d    = k_opsel;
                        state_d = S_OP_SET;
                    end
                end
                default: state_d = S_ENTER_A;
            endcase
        end

        case (state_d)
            S_ENTER_B:  disp_d = b_d;
            S_SHOW_RES: disp_d = res_d;
            default:    disp_d = a_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            disp_q  <= '0;
            op_q    <= OP_ADD;
            ovf_q   <= 1'b0;
            rv_q    <= 1'b0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            disp_q  <= disp_d;
            op_q    <= op_d;
            ovf_q   <= ovf_d;
            rv_q    <= rv_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign operand_a    = a_q;
    assign operand_b    = b_q;
    assign op_code      = op_q;
    assign result       = res_q;
    assign display      = disp_q;
    assign state        = state_q;
    assign overflow     = ovf_q;
    assign result_valid = rv_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed bench for calc_entry_ctrl: keystroke sequences with hand-computed results.
module tb_calc_entry_ctrl;

    localparam int unsigned WIDTH = 16;

    localparam logic [4:0] K_ADD = 5'h10;
    localparam logic [4:0] K_MUL = 5'h11;
    localparam logic [4:0] K_AND = 5'h12;
    localparam logic [4:0] K_EXE = 5'h13;
    localparam logic [4:0] K_SUB = 5'h14;
    localparam logic [4:0] K_OR  = 5'h15;
    localparam logic [4:0] K_CE  = 5'h16;
    localparam logic [4:0] K_CLR = 5'h17;
    localparam logic [4:0] K_BAD = 5'h1F;

    logic             clk;
    logic             rst;
    logic             key_press;
    logic [4:0]       key_val;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [2:0]       op_code;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] display;
    logic [1:0]       state;
    logic             overflow;
    logic             result_valid;

    int checks;
    int errors;

    calc_entry_ctrl #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_press    (key_press),
        .key_val      (key_val),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .op_code      (op_code),
        .result       (result),
        .display      (display),
        .state        (state),
        .overflow     (overflow),
        .result_valid (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One keystroke; returns at the following negedge with outputs updated.
    task automatic key(input logic [4:0] v);
        @(negedge clk);
        key_press = 1'b1;
        key_val   = v;
        @(negedge clk);
        key_press = 1'b0;
        key_val   = 5'h00;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"},     32'(operand_a),    32'h0);
        check({tag, "_b"},     32'(operand_b),    32'h0);
        check({tag, "_op"},    32'(op_code),      32'h0);
        check({tag, "_res"},   32'(result),       32'h0);
        check({tag, "_disp"},  32'(display),      32'h0);
        check({tag, "_state"}, 32'(state),        32'h0);
        check({tag, "_ovf"},   32'(overflow),     32'h0);
        check({tag, "_rv"},    32'(result_valid), 32'h0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        key_press = 1'b1;
        key_val   = 5'h05;

        // Reset wins over a concurrent keystroke.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst       = 1'b1;
        key_press = 1'b0;

        // Digit limit then CE.
        key(5'hF); key(5'hF); key(5'hF); key(5'hF); key(5'h1);
        check("limit_a",    32'(operand_a), 32'hFFFF);
        check("limit_disp", 32'(display),   32'hFFFF);
        key(K_CE);
        check("ce_a",    32'(operand_a), 32'h0);
        check("ce_disp", 32'(display),   32'h0);

        // 12 + 3.
        key(5'h1); key(5'h2); key(K_ADD); key(5'h3);
        check("add_b_disp", 32'(display), 32'h0003);
        check("add_b_state", 32'(state),  32'd2);
        key(K_EXE);
        check("add_res",   32'(result),       32'h0015);
        check("add_disp",  32'(display),      32'h0015);
        check("add_state", 32'(state),        32'd3);
        check("add_rv",    32'(result_valid), 32'h1);
        check("add_ovf",   32'(overflow),     32'h0);
        @(negedge clk);
        check("add_rv_drop", 32'(result_valid), 32'h0);

        // FFFF + 1 carries out; 2 - 3 borrows.
        key(5'hF); key(5'hF); key(5'hF); key(5'hF); key(K_ADD); key(5'h1); key(K_EXE);
        check("ovf_add_res", 32'(result),   32'h0000);
        check("ovf_add_flg", 32'(overflow), 32'h1);
        key(5'h2);
        check("new_a_after_res", 32'(operand_a), 32'h0002);
        check("new_b_cleared",   32'(operand_b), 32'h0000);
        key(K_SUB); key(5'h3); key(K_EXE);
        check("ovf_sub_res", 32'(result),   32'hFFFF);
        check("ovf_sub_flg", 32'(overflow), 32'h1);

        // 4 * 5, chained + 2, then OR 1 continuing from the result.
        key(5'h4); key(K_MUL); key(5'h5); key(K_ADD);
        check("chain_res",   32'(result),       32'h0014);
        check("chain_a",     32'(operand_a),    32'h0014);
        check("chain_b",     32'(operand_b),    32'h0000);
        check("chain_op",    32'(op_code),      32'h0);
        check("chain_state", 32'(state),        32'd1);
        check("chain_rv",    32'(result_valid), 32'h1);
        check("chain_ovf",   32'(overflow),     32'h0);
        key(5'h2); key(K_EXE);
        check("chain_exe", 32'(result), 32'h0016);
        key(K_OR);
        check("cont_a",  32'(operand_a), 32'h0016);
        check("cont_op", 32'(op_code),   32'h4);
        key(5'h1); key(K_EXE);
        check("cont_res", 32'(result), 32'h0017);

        // MUL high half and AND.
        key(5'h1); key(5'h0); key(5'h0); key(K_MUL); key(5'h1); key(5'h0); key(5'h0); key(K_EXE);
        check("mul_res", 32'(result),   32'h0000);
        check("mul_ovf", 32'(overflow), 32'h1);
        key(5'hC); key(K_AND); key(5'hA); key(K_EXE);
        check("and_res", 32'(result),   32'h0008);
        check("and_ovf", 32'(overflow), 32'h0);

        // Ignored inputs, held key_press, CLR.
        key(K_CLR);
        check_all_zero("clr1");
        key(K_BAD);
        check("bad_a",     32'(operand_a), 32'h0);
        check("bad_state", 32'(state),     32'd0);
        key(K_EXE);
        check("exe_a_state", 32'(state),        32'd0);
        check("exe_a_rv",    32'(result_valid), 32'h0);
        @(negedge clk);
        key_press = 1'b1;
        key_val   = 5'h7;
        repeat (3) @(negedge clk);
        key_press = 1'b0;
        check("hold_a", 32'(operand_a), 32'h0777);
        repeat (3) @(negedge clk);
        check("idle_a", 32'(operand_a), 32'h0777);
        key(K_CLR);
        check_all_zero("clr2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_entry_ctrl.md
# calc_entry_ctrl

Calculator entry controller. It sits directly downstream of the on-screen keypad cursor and consumes the 5-bit key code under the cursor whenever the select button is pulsed. It accumulates hexadecimal operands, latches the operator, and computes the result on EXE. It drives the value shown on the display and the status flags.

## Interface

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4
- DIGITS, WIDTH/4, maximum hex digits per operand

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-low reset
- key_press  input  1  one-cycle select pulse from the debounce/edge stage
- key_val  input  5  key code under cursor:
  - 0x00–0x0F: hex digit
  - 0x10 ADD, 0x11 MUL, 0x12 AND, 0x13 EXE, 0x14 SUB, 0x15 OR, 0x16 CE, 0x17 CLR
  - 0x18–0x1F: invalid
- operand_a  output  WIDTH  first operand register
- operand_b  output  WIDTH  second operand register
- op_code  output  3  latched operator: 0 ADD, 1 MUL, 2 AND, 3 SUB, 4 OR
- result  output  WIDTH  last computed result
- display  output  WIDTH  value to show
- state  output  2  0 ENTER_A, 1 OP_SET, 2 ENTER_B, 3 SHOW_RES
- overflow  output  1  sticky flag from the last computation
- result_valid  output  1  one-cycle pulse when result updates

## Operation

General rules:
- key_val is sampled only in cycles where key_press=1. Every cycle with key_press=1 is a separate keystroke.
- Invalid codes (0x18–0x1F) are ignored in every state.
- Digit entry: reg = {reg[WIDTH-5:0], digit} and the digit count increments. Once DIGITS digits have been entered, further digits are ignored. The digit count is internal, one count per operand.
- ALU (combinational, registered into result):
  - ADD: a+b mod 2^WIDTH; overflow = carry out
  - SUB: a−b mod 2^WIDTH; overflow = borrow (a<b)
  - MUL: low WIDTH bits of a*b; overflow = (high WIDTH bits ≠ 0)
  - AND / OR: bitwise; overflow = 0
- CLR, in any state: clear operand_a, operand_b, op_code, result, overflow and both digit counts; go to ENTER_A.

ENTER_A:
- digit: shift into A.
- operator key: latch op_code; go to OP_SET.
- EXE: ignored.
- CE: clear A and its count.

OP_SET:
- digit: B = digit, B count = 1; go to ENTER_B.
- operator key: replace op_code.
- EXE: ignored.
- CE: go to ENTER_A; A is kept.

ENTER_B:
- digit: shift into B.
- EXE: result = ALU(A,B); update overflow; pulse result_valid; go to SHOW_RES.
- operator key (chaining): result = ALU(A,B); A = same value; A count = DIGITS; op_code = new operator; B and B count cleared; pulse result_valid; go to OP_SET.
- CE: clear B and its count; stay in ENTER_B.

SHOW_RES:
- digit: A = digit, A count = 1, B cleared; go to ENTER_A.
- operator key: A = result; latch op_code; B cleared; go to OP_SET.
- EXE: ignored.
- CE: same as CLR.

display selection:
- ENTER_A, OP_SET: operand_a
- ENTER_B: operand_b
- SHOW_RES: result

## Timing

- Reset (rst=0 at a rising edge) has priority over key_press in the same cycle. After reset, all outputs are 0 and state is ENTER_A.
- Every output is registered. A keystroke sampled at edge N is visible on all outputs after edge N; latency is 1 cycle.
- result_valid is high for exactly the cycle following the computing edge. Back-to-back keystrokes on consecutive cycles are fully supported; no busy or stall.
- Reset mid-entry discards all partial state; no computation completes.
- overflow holds its value until the next computation or clear.
- op_code, operand_b and result hold their values between keystrokes. With no key_press, nothing changes.

## Test plan

- **Reset:** rst=0 for 2 cycles with key_press=1 and key_val=0x05 -> all outputs 0, state=0.
- **Add with display:** keys 1,2,ADD,3,EXE -> result=0x0015, display=0x0015, state=3, result_valid high for 1 cycle, overflow=0.
- **Digit limit and CE:** keys F,F,F,F,1 -> A=0xFFFF (fifth digit ignored). Then CE -> A=0, display=0.
- **Overflow:** keys F,F,F,F,ADD,1,EXE -> result=0x0000, overflow=1. Then keys 2,SUB,3,EXE -> result=0xFFFF, overflow=1.
- **Chaining and continuation:** keys 4,MUL,5,ADD,2,EXE -> first operator key gives result=0x0014 and A=0x0014; EXE gives result=0x0016. Then OR,1,EXE -> 0x0017.
- **Ignored inputs and CLR:** key_val=0x1F and EXE in ENTER_A -> no output change. key_press held 3 cycles on digit 7 -> A=0x0777. Then CLR -> everything 0.
